// File: rtl/bar_bin_pkg.sv
// -----------------------------------------------------------------------------
// bar_bin_pkg
// Shared definitions for the bar-code (thermometer) <-> binary blocks.
//   MAX_BIN_W / MAX_BAR_W : largest binary / bar width the payload can carry
//   bin2bar_w(bin_w)      : bar width for a given binary width (2**bin_w)
//   is_bar_legal(v, w)    : 1 when the low w bits of v form a legal bar code
//                           (bit 0 set, no 1 above a 0)
//   stage_pay_t           : per-stage pipeline payload
//                           {remaining vector, partial bin, err, valid}
// -----------------------------------------------------------------------------
package bar_bin_pkg;

  localparam int MAX_BIN_W = 6;
  localparam int MAX_BAR_W = 1 << MAX_BIN_W;

  function automatic int bin2bar_w(input int bin_w);
    return 1 << bin_w;
  endfunction

  function automatic logic is_bar_legal(input logic [MAX_BAR_W-1:0] v,
                                        input int                   w);
    logic ok;
    ok = v[0];
    for (int i = 0; i < MAX_BAR_W - 1; i++) begin
      // A 1 sitting directly above a 0 is a bubble in the thermometer code.
      if ((i + 1 < w) && v[i+1] && !v[i]) ok = 1'b0;
    end
    return ok;
  endfunction

  // vec holds the part of the code still to be decoded, right-aligned and
  // zero-padded; bin collects decided bits MSB-first.
  typedef struct packed {
    logic [MAX_BAR_W-1:0] vec;
    logic [MAX_BIN_W-1:0] bin;
    logic                 err;
    logic                 valid;
  } stage_pay_t;

endpackage

// File: rtl/bar2bin_pipe_if.sv
// -----------------------------------------------------------------------------
// bar2bin_pipe_if
// Handshake bundle of the bar-to-binary decoder.
//   Input side : i_bar, i_valid (producer -> decoder), o_ready (decoder -> producer)
//   Output side: o_bin, o_err, o_valid (decoder -> consumer), i_ready (consumer -> decoder)
// Handshake: a word moves on a rising edge where its valid and the matching
// ready are both 1; valid and data must not change while valid=1 and ready=0.
// Modports: slave = decoder view, master = producer/consumer (test) view.
// -----------------------------------------------------------------------------
interface bar2bin_pipe_if #(
  parameter int BIN_WIDTH = 2
);
  localparam int BAR_WIDTH = 1 << BIN_WIDTH;

  logic [BAR_WIDTH-1:0] i_bar;
  logic                 i_valid;
  logic                 o_ready;
  logic [BIN_WIDTH-1:0] o_bin;
  logic                 o_err;
  logic                 o_valid;
  logic                 i_ready;

  modport slave (
    input  i_bar, i_valid, i_ready,
    output o_ready, o_bin, o_err, o_valid
  );

  modport master (
    output i_bar, i_valid, i_ready,
    input  o_ready, o_bin, o_err, o_valid
  );

endinterface

// File: rtl/bar2bin_stage.sv
// -----------------------------------------------------------------------------
// bar2bin_stage
// One level of the halving decode tree, registered.
//   IN_W  : width of the vector still to decode at this level (power of 2, >= 2)
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset, clears the payload
//   en_i  : global advance enable; when 0 the whole payload holds
//   pay_i : payload from the previous level
//   pay_o : registered payload for the next level
// The decided bit is v[IN_W/2]; it lands at bin bit log2(IN_W)-1 and selects
// which half of v continues down the tree. err and valid pass straight through.
// -----------------------------------------------------------------------------
module bar2bin_stage
  import bar_bin_pkg::*;
#(
  parameter int IN_W = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  stage_pay_t pay_i,
  output stage_pay_t pay_o
);

  localparam int HALF    = IN_W / 2;
  localparam int BIT_POS = $clog2(IN_W) - 1;

  logic [IN_W-1:0] v;
  logic            b;
  stage_pay_t      pay_d;
  stage_pay_t      pay_q;

  assign v = pay_i.vec[IN_W-1:0];
  assign b = v[HALF];

  always_comb begin
    pay_d              = pay_i;
    pay_d.bin[BIT_POS] = b;
    pay_d.vec          = '0;
    pay_d.vec[HALF-1:0] = b ? v[IN_W-1:HALF] : v[HALF-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pay_q <= '0;
    end else if (en_i) begin
      // Bubbles (valid=0) shift like any other entry.
      pay_q <= pay_d;
    end
  end

  assign pay_o = pay_q;

endmodule

// File: rtl/bar2bin_pipe.sv
// -----------------------------------------------------------------------------
// bar2bin_pipe
// Pipelined thermometer (bar) code to binary decoder, one register per level
// of a halving tree; latency BIN_WIDTH cycles, one code per cycle.
//   BIN_WIDTH : binary output width (>= 1, <= MAX_BIN_W); bar width 2**BIN_WIDTH
//   i_clk     : clock, rising edge
//   i_rst     : synchronous active-high reset, discards all in-flight entries
//   bus       : bar2bin_pipe_if.slave
//               i_bar/i_valid/o_ready  - input handshake
//               o_bin/o_err/o_valid/i_ready - output handshake
// Optional macro BAR2BIN_BUBBLE_CHK_EN: when defined, illegal bar codes are
// flagged on o_err alongside their (still tree-decoded) o_bin; when undefined
// no check logic exists and o_err is 0.
// -----------------------------------------------------------------------------
module bar2bin_pipe
  import bar_bin_pkg::*;
#(
  parameter int BIN_WIDTH = 2
) (
  input  logic           i_clk,
  input  logic           i_rst,
  bar2bin_pipe_if.slave  bus
);

  localparam int BAR_WIDTH = bin2bar_w(BIN_WIDTH);

  logic       en;
  logic       chk_err;
  stage_pay_t pay_in;
  stage_pay_t pay_out [BIN_WIDTH];
  logic       unused_tail;

  // Whole pipe advances together: move whenever the output slot is empty or
  // being drained this cycle.
  assign en          = !pay_out[BIN_WIDTH-1].valid | bus.i_ready;
  assign bus.o_ready = en;

`ifdef BAR2BIN_BUBBLE_CHK_EN
  assign chk_err = !is_bar_legal(MAX_BAR_W'(bus.i_bar), BAR_WIDTH);
`else
  assign chk_err = 1'b0;
`endif

  always_comb begin
    pay_in                    = '0;
    pay_in.vec[BAR_WIDTH-1:0] = bus.i_bar;
    pay_in.err                = chk_err;
    pay_in.valid              = bus.i_valid;
  end

  for (genvar k = 0; k < BIN_WIDTH; k++) begin : g_stage
    stage_pay_t stg_in;
    if (k == 0) begin : g_first
      assign stg_in = pay_in;
    end else begin : g_next
      assign stg_in = pay_out[k-1];
    end

    bar2bin_stage #(
      .IN_W (bin2bar_w(BIN_WIDTH - k))
    ) u_stage (
      .clk_i (i_clk),
      .rst_i (i_rst),
      .en_i  (en),
      .pay_i (stg_in),
      .pay_o (pay_out[k])
    );
  end

  assign bus.o_bin   = pay_out[BIN_WIDTH-1].bin[BIN_WIDTH-1:0];
  assign bus.o_err   = pay_out[BIN_WIDTH-1].err;
  assign bus.o_valid = pay_out[BIN_WIDTH-1].valid;

  // Leftover vector bits and unused high bin bits of the last level.
  assign unused_tail = ^{pay_out[BIN_WIDTH-1].vec, pay_out[BIN_WIDTH-1].bin};

endmodule

// File: tb/tb_bar2bin_pipe.sv
// -----------------------------------------------------------------------------
// tb_bar2bin_pipe
// Bench for bar2bin_pipe with three builds side by side: BIN_WIDTH = 1, 2, 4.
// Honours BAR2BIN_BUBBLE_CHK_EN for the expected o_err of illegal codes.
// -----------------------------------------------------------------------------
module tb_bar2bin_pipe;

`ifdef BAR2BIN_BUBBLE_CHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bar2bin_pipe_if #(.BIN_WIDTH(1)) bus1 ();
  bar2bin_pipe_if #(.BIN_WIDTH(2)) bus2 ();
  bar2bin_pipe_if #(.BIN_WIDTH(4)) bus4 ();

  bar2bin_pipe #(.BIN_WIDTH(1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));
  bar2bin_pipe #(.BIN_WIDTH(2)) dut2 (.i_clk(clk), .i_rst(rst), .bus(bus2));
  bar2bin_pipe #(.BIN_WIDTH(4)) dut4 (.i_clk(clk), .i_rst(rst), .bus(bus4));

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];

  logic [3:0]  s_code [8];
  logic [1:0]  s_bin  [8];
  logic        s_err  [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus1.i_bar = '0; bus1.i_valid = 1'b0; bus1.i_ready = 1'b1;
    bus2.i_bar = '0; bus2.i_valid = 1'b0; bus2.i_ready = 1'b1;
    bus4.i_bar = '0; bus4.i_valid = 1'b0; bus4.i_ready = 1'b1;
  endtask

  // Stream s_code[0..n-1] back to back into the BIN_WIDTH=2 build with
  // i_ready=1; each result must appear exactly 2 cycles after its accept.
  task automatic w2_stream(input string name, input int n);
    for (int c = 0; c <= n; c++) begin
      if (c < n) begin
        bus2.i_bar   = s_code[c];
        bus2.i_valid = 1'b1;
      end else begin
        bus2.i_valid = 1'b0;
      end
      tick();
      if (c == 0) begin
        check($sformatf("%s_fill_valid", name), 32'(bus2.o_valid), 32'd0);
      end else begin
        check($sformatf("%s_valid%0d", name, c-1), 32'(bus2.o_valid), 32'd1);
        check($sformatf("%s_bin%0d", name, c-1), 32'(bus2.o_bin), 32'(s_bin[c-1]));
        check($sformatf("%s_err%0d", name, c-1), 32'(bus2.o_err), 32'(s_err[c-1]));
      end
    end
    tick();
    check($sformatf("%s_drain_valid", name), 32'(bus2.o_valid), 32'd0);
  endtask

  // One code through the BIN_WIDTH=4 build: invisible for 3 cycles, out on the 4th.
  task automatic w4_single(input string name, input logic [15:0] code,
                           input logic [3:0] bin_e, input logic err_e);
    bus4.i_bar   = code;
    bus4.i_valid = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      bus4.i_valid = 1'b0;
      if (c < 4) begin
        check($sformatf("%s_lat%0d", name, c), 32'(bus4.o_valid), 32'd0);
      end
    end
    check($sformatf("%s_valid", name), 32'(bus4.o_valid), 32'd1);
    check($sformatf("%s_bin", name), 32'(bus4.o_bin), 32'(bin_e));
    check($sformatf("%s_err", name), 32'(bus4.o_err), 32'(err_e));
    tick();
    check($sformatf("%s_after", name), 32'(bus4.o_valid), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          sent;
    int          got;
    logic [15:0] code;
    logic [31:0] e;

    rst = 1'b1;
    idle_all();
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    check("rst_valid1", 32'(bus1.o_valid), 32'd0);
    check("rst_valid2", 32'(bus2.o_valid), 32'd0);
    check("rst_valid4", 32'(bus4.o_valid), 32'd0);
    check("rst_bin2",   32'(bus2.o_bin),   32'd0);
    check("rst_err2",   32'(bus2.o_err),   32'd0);
    check("rst_bin4",   32'(bus4.o_bin),   32'd0);
    bus2.i_ready = 1'b0;
    #1;
    check("rst_ready2", 32'(bus2.o_ready), 32'd1);
    bus2.i_ready = 1'b1;

    // Legal stream 0001,0011,0111,1111 -> 0,1,2,3
    s_code[0] = 4'b0001; s_bin[0] = 2'd0; s_err[0] = 1'b0;
    s_code[1] = 4'b0011; s_bin[1] = 2'd1; s_err[1] = 1'b0;
    s_code[2] = 4'b0111; s_bin[2] = 2'd2; s_err[2] = 1'b0;
    s_code[3] = 4'b1111; s_bin[3] = 2'd3; s_err[3] = 1'b0;
    w2_stream("legal", 4);

    // Illegal codes still tree-decode
    s_code[0] = 4'b0101; s_bin[0] = 2'b10; s_err[0] = ERR_EXP;
    s_code[1] = 4'b0000; s_bin[1] = 2'b00; s_err[1] = ERR_EXP;
    w2_stream("illegal", 2);

    // Backpressure: hold result 1 for 3 cycles, then drain 2 and 3
    bus2.i_bar = 4'b0011; bus2.i_valid = 1'b1;
    tick();
    bus2.i_bar = 4'b0111;
    tick();
    check("bp_first_valid", 32'(bus2.o_valid), 32'd1);
    check("bp_first_bin",   32'(bus2.o_bin),   32'd1);
    bus2.i_ready = 1'b0;
    bus2.i_bar   = 4'b1111;
    #1;
    check("bp_ready_low", 32'(bus2.o_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("bp_hold_valid%0d", c), 32'(bus2.o_valid), 32'd1);
      check($sformatf("bp_hold_bin%0d", c),   32'(bus2.o_bin),   32'd1);
      check($sformatf("bp_hold_ready%0d", c), 32'(bus2.o_ready), 32'd0);
    end
    bus2.i_ready = 1'b1;
    #1;
    check("bp_ready_back", 32'(bus2.o_ready), 32'd1);
    tick();
    bus2.i_valid = 1'b0;
    check("bp_next_valid", 32'(bus2.o_valid), 32'd1);
    check("bp_next_bin",   32'(bus2.o_bin),   32'd2);
    tick();
    check("bp_last_valid", 32'(bus2.o_valid), 32'd1);
    check("bp_last_bin",   32'(bus2.o_bin),   32'd3);
    tick();
    check("bp_empty", 32'(bus2.o_valid), 32'd0);

    // Reset with two entries in flight
    bus2.i_bar = 4'b0111; bus2.i_valid = 1'b1;
    tick();
    bus2.i_bar = 4'b1111;
    tick();
    check("mr_pre_valid", 32'(bus2.o_valid), 32'd1);
    check("mr_pre_bin",   32'(bus2.o_bin),   32'd2);
    rst = 1'b1;
    bus2.i_valid = 1'b0;
    tick();
    rst = 1'b0;
    check("mr_valid", 32'(bus2.o_valid), 32'd0);
    check("mr_bin",   32'(bus2.o_bin),   32'd0);
    for (int c = 0; c < 2; c++) begin
      tick();
      check($sformatf("mr_stale%0d", c), 32'(bus2.o_valid), 32'd0);
    end
    bus2.i_bar = 4'b0011; bus2.i_valid = 1'b1;
    tick();
    bus2.i_valid = 1'b0;
    check("mr_new_lat1", 32'(bus2.o_valid), 32'd0);
    tick();
    check("mr_new_valid", 32'(bus2.o_valid), 32'd1);
    check("mr_new_bin",   32'(bus2.o_bin),   32'd1);
    tick();
    check("mr_new_empty", 32'(bus2.o_valid), 32'd0);

    // BIN_WIDTH=1: latency 1, o_bin = i_bar[1]
    bus1.i_bar = 2'b11; bus1.i_valid = 1'b1;
    tick();
    check("w1_11_valid", 32'(bus1.o_valid), 32'd1);
    check("w1_11_bin",   32'(bus1.o_bin),   32'd1);
    check("w1_11_err",   32'(bus1.o_err),   32'd0);
    bus1.i_bar = 2'b01;
    tick();
    check("w1_01_bin", 32'(bus1.o_bin), 32'd0);
    bus1.i_bar = 2'b10;
    tick();
    bus1.i_valid = 1'b0;
    check("w1_10_bin", 32'(bus1.o_bin), 32'd1);
    check("w1_10_err", 32'(bus1.o_err), 32'(ERR_EXP));
    tick();
    check("w1_empty", 32'(bus1.o_valid), 32'd0);

    // BIN_WIDTH=4 directed
    w4_single("w4_01ff", 16'h01FF, 4'd8, 1'b0);
    w4_single("w4_00f1", 16'h00F1, 4'd7, ERR_EXP);

    // BIN_WIDTH=4 legal sweep under random backpressure
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
      bus4.i_ready = ($urandom_range(0, 3) != 0);
      code = 16'((32'd1 << (sent + 1)) - 32'd1);
      if (sent < 16) begin
        bus4.i_bar   = code;
        bus4.i_valid = 1'b1;
      end else begin
        bus4.i_valid = 1'b0;
      end
      #1;
      if (bus4.o_valid && bus4.i_ready) begin
        if (exp_q.size() == 0) begin
          check("w4_sweep_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("w4_sweep_bin%0d", got), 32'(bus4.o_bin), e);
          check($sformatf("w4_sweep_err%0d", got), 32'(bus4.o_err), 32'd0);
          got++;
        end
      end
      if (bus4.i_valid && bus4.o_ready) begin
        exp_q.push_back(32'($countones(code)) - 32'd1);
        sent++;
      end
      tick();
    end
    bus4.i_valid = 1'b0;
    bus4.i_ready = 1'b1;
    check("w4_sweep_count", 32'(got), 32'd16);
    check("w4_sweep_left",  32'(exp_q.size()), 32'd0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
